// File: rtl/netwalk_egress_record_reader_if.sv
// Bundle between the egress FIFO read side, the record reader and the host consumer.
// master = the record reader, slave = FIFO model plus record consumer.
interface netwalk_egress_record_reader_if #(
  parameter int ERR_CNT_WIDTH = 16,
  parameter int REC_CNT_WIDTH = 32
) ();
  logic [127:0]               egress_pcie_data_i;
  logic                       egress_pcie_empty_i;
  logic                       egress_pcie_rd_o;
  logic                       rec_valid_o;
  logic                       rec_ready_i;
  logic                       rec_table_missed_o;
  logic [5:0]                 rec_flow_addr_o;
  logic [4:0]                 rec_flow_tag_o;
  logic [31:0]                rec_flow_count_o;
  logic [31:0]                rec_pkt_hi_o;
  logic [511:0]               rec_pkt_data_o;
  logic [REC_CNT_WIDTH-1:0]   rec_cnt_o;
  logic [ERR_CNT_WIDTH-1:0]   sync_err_cnt_o;

  modport master (
    input  egress_pcie_data_i, egress_pcie_empty_i, rec_ready_i,
    output egress_pcie_rd_o, rec_valid_o, rec_table_missed_o, rec_flow_addr_o,
           rec_flow_tag_o, rec_flow_count_o, rec_pkt_hi_o, rec_pkt_data_o,
           rec_cnt_o, sync_err_cnt_o
  );

  modport slave (
    output egress_pcie_data_i, egress_pcie_empty_i, rec_ready_i,
    input  egress_pcie_rd_o, rec_valid_o, rec_table_missed_o, rec_flow_addr_o,
           rec_flow_tag_o, rec_flow_count_o, rec_pkt_hi_o, rec_pkt_data_o,
           rec_cnt_o, sync_err_cnt_o
  );
endinterface

// File: rtl/netwalk_egress_record_reader.sv
// Pops 128b beats from the egress FIFO, aligns 8-beat meta+packet records on the marker,
// decodes them and holds one record at a time on a valid/ready port.
module netwalk_egress_record_reader #(
  parameter logic [31:0] MARKER        = 32'hCCCCCCCC,
  parameter int          ERR_CNT_WIDTH = 16,
  parameter int          REC_CNT_WIDTH = 32
) (
  input  logic                                  egress_pcie_clk_i,
  input  logic                                  egress_pcie_rst_n_i,
  netwalk_egress_record_reader_if.master        bus
);

  typedef enum logic [1:0] {HUNT, META, PKT, HOLD} state_t;

  state_t                     r_state;
  state_t                     w_nextState;
  logic                       r_rdQ;
  logic [1:0]                 r_beatIdx;
  logic [127:0]               w_beat;
  logic                       w_markerHi;
  logic                       w_markerLo;
  logic                       w_accept;
  logic                       w_rd;
  logic                       w_errInc;

  logic                       r_metaMissed;
  logic [5:0]                 r_metaAddr;
  logic [4:0]                 r_metaTag;
  logic [31:0]                r_metaCount;
  logic [31:0]                r_metaPktHi;
  logic [383:0]               r_pktSr;

  logic                       r_recValid;
  logic                       r_recMissed;
  logic [5:0]                 r_recAddr;
  logic [4:0]                 r_recTag;
  logic [31:0]                r_recCount;
  logic [31:0]                r_recPktHi;
  logic [511:0]               r_recPktData;
  logic [REC_CNT_WIDTH-1:0]   r_recCnt;
  logic [ERR_CNT_WIDTH-1:0]   r_syncErrCnt;

  assign w_beat     = bus.egress_pcie_data_i;
  assign w_markerHi = (w_beat[127:96] == MARKER);
  assign w_markerLo = (w_beat[31:0] == MARKER);
  assign w_accept   = r_recValid && bus.rec_ready_i;

  always_ff @(posedge egress_pcie_clk_i or negedge egress_pcie_rst_n_i) begin
    if (!egress_pcie_rst_n_i) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A beat is only acted on when r_rdQ marks the FIFO dout as freshly popped.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      HUNT:    if (r_rdQ && w_markerHi) w_nextState = META;
      META:    if (r_rdQ && (r_beatIdx == 2'd3)) w_nextState = w_markerLo ? PKT : HUNT;
      PKT:     if (r_rdQ && (r_beatIdx == 2'd3)) w_nextState = HOLD;
      HOLD:    if (w_accept) w_nextState = HUNT;
      default: w_nextState = HUNT;
    endcase
  end

  always_comb begin
    w_rd     = 1'b0;
    w_errInc = 1'b0;
    if (egress_pcie_rst_n_i && !bus.egress_pcie_empty_i && !r_rdQ && (r_state != HOLD)) begin
      w_rd = 1'b1;
    end
    if (r_rdQ) begin
      if ((r_state == HUNT) && !w_markerHi) begin
        w_errInc = 1'b1;
      end
      if ((r_state == META) && (r_beatIdx == 2'd3) && !w_markerLo) begin
        w_errInc = 1'b1;
      end
    end
  end

  always_ff @(posedge egress_pcie_clk_i or negedge egress_pcie_rst_n_i) begin
    if (!egress_pcie_rst_n_i) begin
      r_rdQ        <= 1'b0;
      r_beatIdx    <= 2'd0;
      r_metaMissed <= 1'b0;
      r_metaAddr   <= 6'd0;
      r_metaTag    <= 5'd0;
      r_metaCount  <= 32'd0;
      r_metaPktHi  <= 32'd0;
      r_pktSr      <= '0;
      r_recValid   <= 1'b0;
      r_recMissed  <= 1'b0;
      r_recAddr    <= 6'd0;
      r_recTag     <= 5'd0;
      r_recCount   <= 32'd0;
      r_recPktHi   <= 32'd0;
      r_recPktData <= '0;
      r_recCnt     <= '0;
      r_syncErrCnt <= '0;
    end else begin
      r_rdQ <= w_rd;
      if (w_accept) begin
        r_recValid <= 1'b0;
        r_recCnt   <= r_recCnt + REC_CNT_WIDTH'(1);
      end
      if (w_errInc && (r_syncErrCnt != '1)) begin
        r_syncErrCnt <= r_syncErrCnt + ERR_CNT_WIDTH'(1);
      end
      if (r_rdQ) begin
        unique case (r_state)
          HUNT: begin
            if (w_markerHi) r_beatIdx <= 2'd1;
          end
          META: begin
            r_beatIdx <= r_beatIdx + 2'd1;
            // Every decoded field lives in the last (LSB) meta quarter.
            if (r_beatIdx == 2'd3) begin
              r_metaMissed <= w_beat[112];
              r_metaAddr   <= w_beat[109:104];
              r_metaTag    <= w_beat[100:96];
              r_metaCount  <= w_beat[95:64];
              r_metaPktHi  <= w_beat[63:32];
            end
          end
          PKT: begin
            r_beatIdx <= r_beatIdx + 2'd1;
            r_pktSr   <= {r_pktSr[255:0], w_beat};
            if (r_beatIdx == 2'd3) begin
              r_recValid   <= 1'b1;
              r_recMissed  <= r_metaMissed;
              r_recAddr    <= r_metaAddr;
              r_recTag     <= r_metaTag;
              r_recCount   <= r_metaCount;
              r_recPktHi   <= r_metaPktHi;
              r_recPktData <= {r_pktSr, w_beat};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.egress_pcie_rd_o   = w_rd;
  assign bus.rec_valid_o        = r_recValid;
  assign bus.rec_table_missed_o = r_recMissed;
  assign bus.rec_flow_addr_o    = r_recAddr;
  assign bus.rec_flow_tag_o     = r_recTag;
  assign bus.rec_flow_count_o   = r_recCount;
  assign bus.rec_pkt_hi_o       = r_recPktHi;
  assign bus.rec_pkt_data_o     = r_recPktData;
  assign bus.rec_cnt_o          = r_recCnt;
  assign bus.sync_err_cnt_o     = r_syncErrCnt;

endmodule

// File: tb/tb_netwalk_egress_record_reader.sv
// Scoreboard bench for netwalk_egress_record_reader: a queue-backed FIFO model feeds beats,
// expected records go into a scoreboard and a negedge monitor checks every accepted record.
module tb_netwalk_egress_record_reader;

  localparam logic [31:0] MARKER = 32'hCCCCCCCC;

  typedef struct {
    logic         missed;
    logic [5:0]   addr;
    logic [4:0]   tag;
    logic [31:0]  count;
    logic [31:0]  hi;
    logic [511:0] pkt;
  } rec_t;

  logic         clk;
  logic         rst_n;
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           firstPopCyc = 0;
  int           popTotal = 0;
  int           popWhileEmpty = 0;
  logic [127:0] fifoQ[$];
  rec_t         sb[$];
  rec_t         monExp;

  netwalk_egress_record_reader_if #(.ERR_CNT_WIDTH(16), .REC_CNT_WIDTH(32)) bus ();

  netwalk_egress_record_reader #(
    .MARKER(MARKER), .ERR_CNT_WIDTH(16), .REC_CNT_WIDTH(32)
  ) dut (
    .egress_pcie_clk_i   (clk),
    .egress_pcie_rst_n_i (rst_n),
    .bus                 (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIFO model: dout is updated on the pop edge, so it is valid the cycle after rd_en.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      fifoQ.delete();
      popTotal <= 0;
    end else if (bus.egress_pcie_rd_o) begin
      if (bus.egress_pcie_empty_i) begin
        popWhileEmpty <= popWhileEmpty + 1;
      end else begin
        bus.egress_pcie_data_i <= fifoQ.pop_front();
        if (popTotal == 0) firstPopCyc <= cyc;
        popTotal <= popTotal + 1;
      end
    end
  end

  always @(negedge clk) begin
    bus.egress_pcie_empty_i <= (fifoQ.size() == 0);
  end

  always @(negedge clk) begin
    if (rst_n && bus.rec_valid_o && bus.rec_ready_i) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_record", 1'b1, 1'b0);
      end else begin
        monExp = sb.pop_front();
        checkOutput("rec_table_missed", bus.rec_table_missed_o, monExp.missed);
        checkOutput("rec_flow_addr",    bus.rec_flow_addr_o,    monExp.addr);
        checkOutput("rec_flow_tag",     bus.rec_flow_tag_o,     monExp.tag);
        checkOutput("rec_flow_count",   bus.rec_flow_count_o,   monExp.count);
        checkOutput("rec_pkt_hi",       bus.rec_pkt_hi_o,       monExp.hi);
        checkOutput("rec_pkt_data",     bus.rec_pkt_data_o,     monExp.pkt);
      end
    end
  end

  function automatic logic [511:0] buildMeta(input rec_t r, input logic [31:0] trailer);
    logic [511:0] m;
    m            = '0;
    m[511:480]   = MARKER;
    m[31:0]      = trailer;
    m[112]       = r.missed;
    m[109:104]   = r.addr;
    m[100:96]    = r.tag;
    m[95:64]     = r.count;
    m[63:32]     = r.hi;
    return m;
  endfunction

  task automatic pushWord(input logic [511:0] w, input int nBeats);
    for (int i = 0; i < nBeats; i++) fifoQ.push_back(w[511 - 128*i -: 128]);
  endtask

  task automatic applyStimulus(input rec_t r);
    pushWord(buildMeta(r, MARKER), 4);
    pushWord(r.pkt, 4);
    sb.push_back(r);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic waitPops(input string name, input int target, input int limit);
    for (int n = 0; n < limit && popTotal < target; n++) begin
      @(posedge clk); #1;
    end
    checkOutput(name, popTotal, target);
  endtask

  task automatic waitDrain(input string name, input int limit);
    for (int n = 0; n < limit && sb.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    checkOutput(name, sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rec_t         r1, rA, rB, rC, rD, rE, rF, rG, rH;
    logic [127:0] junk [3];
    logic [127:0] beats [8];
    logic [511:0] metaF;
    int           rdHigh;
    int           base;

    rst_n              = 1'b0;
    bus.rec_ready_i    = 1'b1;

    r1 = '{1'b1, 6'h2A, 5'h11, 32'h5,        32'hDEADBEEF, 512'h0123};
    rA = '{1'b0, 6'h01, 5'h02, 32'h00000100, 32'h11112222, {16{32'hA5A50001}}};
    rB = '{1'b1, 6'h3F, 5'h1F, 32'hFFFFFFFF, 32'h33334444, {16{32'h5A5A0002}}};
    rC = '{1'b0, 6'h15, 5'h0A, 32'h12345678, 32'hCAFEF00D, {8{64'h0F0E0D0C0B0A0908}}};
    rD = '{1'b1, 6'h07, 5'h03, 32'h00000077, 32'hBADBAD00, {16{32'h77777777}}};
    rE = '{1'b1, 6'h22, 5'h14, 32'h00ABCDEF, 32'h01020304, {16{32'h13579BDF}}};
    rF = '{1'b0, 6'h30, 5'h05, 32'h0000BEEF, 32'h89ABCDEF, {16{32'h2468ACE0}}};
    rG = '{1'b1, 6'h0F, 5'h0F, 32'h0000F00F, 32'h55555555, {16{32'hEEEE1111}}};
    rH = '{1'b0, 6'h2D, 5'h16, 32'h00000042, 32'hFEEDFACE, {16{32'h0BADCAFE}}};

    // Reset state
    resetDut();
    checkOutput("reset_rec_valid", bus.rec_valid_o, 1'b0);
    checkOutput("reset_rec_cnt",   bus.rec_cnt_o, 32'd0);
    checkOutput("reset_sync_err",  bus.sync_err_cnt_o, 16'd0);

    $display("[TB] T1 single record");
    applyStimulus(r1);
    for (int n = 0; n < 100 && !bus.rec_valid_o; n++) @(negedge clk);
    checkOutput("T1_valid_seen", bus.rec_valid_o, 1'b1);
    checkOutput("T1_latency", cyc - firstPopCyc, 16);
    waitDrain("T1_drain", 50);
    checkOutput("T1_rec_cnt", bus.rec_cnt_o, 32'd1);

    $display("[TB] T2 backpressure");
    resetDut();
    bus.rec_ready_i = 1'b0;
    applyStimulus(rA);
    applyStimulus(rB);
    for (int n = 0; n < 100 && !bus.rec_valid_o; n++) begin
      @(posedge clk); #1;
    end
    rdHigh = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.egress_pcie_rd_o) rdHigh++;
    end
    checkOutput("T2_rd_in_hold", rdHigh, 0);
    checkOutput("T2_valid_held", bus.rec_valid_o, 1'b1);
    checkOutput("T2_hold_pkt",   bus.rec_pkt_data_o, rA.pkt);
    checkOutput("T2_hold_count", bus.rec_flow_count_o, rA.count);
    checkOutput("T2_hold_cnt",   bus.rec_cnt_o, 32'd0);
    bus.rec_ready_i = 1'b1;
    waitDrain("T2_drain", 200);
    checkOutput("T2_rec_cnt", bus.rec_cnt_o, 32'd2);

    $display("[TB] T3 misalignment");
    resetDut();
    junk[0] = 128'h01234567_89ABCDEF_CCCCCCCC_CCCCCCCC;
    junk[1] = 128'hCCCCCCC0_00000000_00000000_00000000;
    junk[2] = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
    for (int i = 0; i < 3; i++) fifoQ.push_back(junk[i]);
    applyStimulus(rC);
    waitDrain("T3_drain", 100);
    checkOutput("T3_sync_err", bus.sync_err_cnt_o, 16'd3);
    checkOutput("T3_rec_cnt",  bus.rec_cnt_o, 32'd1);

    $display("[TB] T4 bad trailer");
    resetDut();
    pushWord(buildMeta(rD, 32'h0), 4);
    applyStimulus(rE);
    waitDrain("T4_drain", 100);
    checkOutput("T4_sync_err", bus.sync_err_cnt_o, 16'd1);
    checkOutput("T4_rec_cnt",  bus.rec_cnt_o, 32'd1);

    $display("[TB] T5 gappy FIFO");
    resetDut();
    metaF = buildMeta(rF, MARKER);
    for (int i = 0; i < 4; i++) begin
      beats[i]     = metaF[511 - 128*i -: 128];
      beats[i + 4] = rF.pkt[511 - 128*i -: 128];
    end
    sb.push_back(rF);
    for (int i = 0; i < 8; i++) begin
      fifoQ.push_back(beats[i]);
      waitPops("T5_pop", i + 1, 20);
      repeat (5) @(posedge clk);
      #1;
    end
    waitDrain("T5_drain", 50);
    checkOutput("T5_pop_while_empty", popWhileEmpty, 0);
    checkOutput("T5_rec_cnt", bus.rec_cnt_o, 32'd1);

    $display("[TB] T6 reset mid-record");
    base = popTotal;
    pushWord(buildMeta(rG, MARKER), 3);
    waitPops("T6_pop", base + 3, 30);
    @(posedge clk); #1;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("T6_rst_rd",     bus.egress_pcie_rd_o, 1'b0);
    checkOutput("T6_rst_valid",  bus.rec_valid_o, 1'b0);
    checkOutput("T6_rst_cnt",    bus.rec_cnt_o, 32'd0);
    checkOutput("T6_rst_missed", bus.rec_table_missed_o, 1'b0);
    checkOutput("T6_rst_count",  bus.rec_flow_count_o, 32'd0);
    checkOutput("T6_rst_pkt",    bus.rec_pkt_data_o, 512'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(rH);
    waitDrain("T6_drain", 100);
    checkOutput("T6_rec_cnt",  bus.rec_cnt_o, 32'd1);
    checkOutput("T6_sync_err", bus.sync_err_cnt_o, 16'd0);

    checkOutput("final_scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
